reg_exec_seq: RTL and testbench

- Single-issue execute sequencer that sits directly in front of the 16x32 register file.
- Accepts one packed instruction at a time over a valid/ready handshake.
- Drives the register file read port, computes the ALU result from the returned operands, and drives the write port for write-back.
- Multi-cycle FSM; one instruction completes every 4 cycles.

---
 rtl/reg_exec_pkg.sv | 41 ++++
 rtl/reg_exec_alu.sv | 46 ++++
 rtl/reg_exec_seq.sv | 140 ++++++++++++++
 tb/tb_reg_exec_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_exec_pkg.sv
// Shared definitions for the reg_exec_seq execute sequencer: opcodes, FSM
// states, instruction field offsets and the write-back decode.
package reg_exec_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_OPC_W  = 4;

  // Instruction layout: [15:12] opc, [11:8] rd, [7:4] rs1, [3:0] rs2
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int SHAMT_W = 5;

  localparam logic [DEF_OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [DEF_OPC_W-1:0] OP_SUB  = 4'h1;
  localparam logic [DEF_OPC_W-1:0] OP_AND  = 4'h2;
  localparam logic [DEF_OPC_W-1:0] OP_OR   = 4'h3;
  localparam logic [DEF_OPC_W-1:0] OP_XOR  = 4'h4;
  localparam logic [DEF_OPC_W-1:0] OP_SLL  = 4'h5;
  localparam logic [DEF_OPC_W-1:0] OP_SRL  = 4'h6;
  localparam logic [DEF_OPC_W-1:0] OP_SRA  = 4'h7;
  localparam logic [DEF_OPC_W-1:0] OP_SLT  = 4'h8;
  localparam logic [DEF_OPC_W-1:0] OP_SLTU = 4'h9;
  localparam logic [DEF_OPC_W-1:0] OP_MOV  = 4'hA;
  localparam logic [DEF_OPC_W-1:0] OP_NOP  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Opcodes ADD..MOV are the only ones that update result and the register file.
  function automatic logic writes_back(input logic [DEF_OPC_W-1:0] opc);
    return (opc <= OP_MOV);
  endfunction

endpackage

// File: rtl/reg_exec_alu.sv
// Combinational ALU for reg_exec_seq; legal_o is low for opcodes above NOP.
module reg_exec_alu
  import reg_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic [OPC_W-1:0]  opc_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              legal_o
);

  logic [DATA_W:0]    sum;
  logic [DATA_W:0]    diff;
  logic [SHAMT_W-1:0] shamt;

  // The extra top bit of diff is the unsigned borrow.
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHAMT_W-1:0];

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    legal_o  = 1'b1;
    case (opc_i)
      OP_ADD:  {carry_o, result_o} = sum;
      OP_SUB:  {carry_o, result_o} = diff;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = DATA_W'($signed(a_i) >>> shamt);
      OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      OP_MOV:  result_o = a_i;
      OP_NOP:  result_o = '0;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_exec_seq.sv
// Single-issue execute sequencer driving a 16x32 register file (IDLE/READ/EXEC/WB).
// Optional EXEC_RETIRE_CNT_EN adds a 32-bit retire counter output.
module reg_exec_seq
  import reg_exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef EXEC_RETIRE_CNT_EN
  output logic [31:0]               retire_cnt,
`endif
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [OPC_W+3*ADDR_W-1:0] instr,
  output logic                      rf_en,
  output logic                      rf_rd,
  output logic                      rf_wr,
  output logic [ADDR_W-1:0]         rf_sel_o1,
  output logic [ADDR_W-1:0]         rf_sel_o2,
  output logic [ADDR_W-1:0]         rf_sel_i1,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [DATA_W-1:0]         rf_op1,
  input  logic [DATA_W-1:0]         rf_op2,
  output logic                      done,
  output logic [DATA_W-1:0]         result,
  output logic                      zero,
  output logic                      carry,
  output logic                      illegal
);

  localparam int INSTR_W = OPC_W + 3*ADDR_W;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready depends only on the FSM state.
  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                rf_en_q, rf_rd_q, rf_wr_q;
  logic [ADDR_W-1:0]   rf_sel_o1_q, rf_sel_o2_q, rf_sel_i1_q;
  logic [DATA_W-1:0]   rf_wdata_q, result_q;
  logic                zero_q, carry_q, done_q, illegal_q;

  logic [OPC_W-1:0]    opc;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_legal;
  logic                rd_d, wr_d, wb;

  assign opc = instr_q[OPC_LSB +: OPC_W];
  assign wb  = writes_back(opc);

  reg_exec_alu #(.DATA_W(DATA_W), .OPC_W(OPC_W)) u_alu (
    .opc_i    (opc),
    .a_i      (rf_op1),
    .b_i      (rf_op2),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .legal_o  (alu_legal)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: if (instr_valid) begin
        instr_d = instr;
        state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Port strobes are registered from the next state so they line up with it.
  assign rd_d        = (state_d == ST_READ);
  assign wr_d        = (state_d == ST_WB) && wb;
  assign instr_ready = (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      rf_en_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      rf_sel_o1_q <= '0;
      rf_sel_o2_q <= '0;
      rf_sel_i1_q <= '0;
      rf_wdata_q  <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rf_en_q     <= rd_d | wr_d;
      rf_rd_q     <= rd_d;
      rf_wr_q     <= wr_d;
      rf_sel_o1_q <= rd_d ? instr_d[RS1_LSB +: ADDR_W] : '0;
      rf_sel_o2_q <= rd_d ? instr_d[RS2_LSB +: ADDR_W] : '0;
      rf_sel_i1_q <= wr_d ? instr_q[RD_LSB +: ADDR_W] : '0;
      rf_wdata_q  <= wr_d ? alu_result : '0;
      done_q      <= (state_d == ST_WB);
      illegal_q   <= (state_d == ST_WB) && !alu_legal;
      if ((state_q == ST_EXEC) && wb) begin
        result_q <= alu_result;
        zero_q   <= (alu_result == '0);
        carry_q  <= alu_carry;
      end
    end
  end

`ifdef EXEC_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt_q <= '0;
    else if (done_q) retire_cnt_q <= retire_cnt_q + 32'd1;
  end
  assign retire_cnt = retire_cnt_q;
`endif

  assign rf_en     = rf_en_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wr     = rf_wr_q;
  assign rf_sel_o1 = rf_sel_o1_q;
  assign rf_sel_o2 = rf_sel_o2_q;
  assign rf_sel_i1 = rf_sel_i1_q;
  assign rf_wdata  = rf_wdata_q;
  assign done      = done_q;
  assign illegal   = illegal_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_reg_exec_seq.sv
// Self-checking bench for reg_exec_seq with a registered-read register file model.
module tb_reg_exec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        rf_en, rf_rd, rf_wr;
  logic [3:0]  rf_sel_o1, rf_sel_o2, rf_sel_i1;
  logic [31:0] rf_wdata, rf_op1, rf_op2, result;
  logic        done, zero, carry, illegal;
`ifdef EXEC_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  reg_exec_seq dut (
    .clk         (clk),
    .rst         (rst),
`ifdef EXEC_RETIRE_CNT_EN
    .retire_cnt  (retire_cnt),
`endif
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_en       (rf_en),
    .rf_rd       (rf_rd),
    .rf_wr       (rf_wr),
    .rf_sel_o1   (rf_sel_o1),
    .rf_sel_o2   (rf_sel_o2),
    .rf_sel_i1   (rf_sel_i1),
    .rf_wdata    (rf_wdata),
    .rf_op1      (rf_op1),
    .rf_op2      (rf_op2),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .carry       (carry),
    .illegal     (illegal)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register file model ----------------
  logic [31:0] regs [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (rf_en && rf_rd) begin
      rf_op1 <= regs[rf_sel_o1];
      rf_op2 <= regs[rf_sel_o2];
    end
    if (rf_en && rf_wr) regs[rf_sel_i1] <= rf_wdata;
    if (pl_en) regs[pl_addr] <= pl_data;
    if (rf_wr) wr_cnt <= wr_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // entry: {illegal, wr, zero, carry, rd_or_0[3:0], result[31:0]}
  logic [39:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] mregs [16];
  logic [31:0] mres = '0;
  logic        mzero = 1'b0, mcarry = 1'b0;
  int          retire_exp = 0;
  int          last_acc = 0;
  bit          prev_keep = 1'b0;

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("SB_EMPTY", 1, 0);
      else begin
        logic [39:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("RETIRE", {illegal, rf_wr, zero, carry, rf_sel_i1, result}, e);
        chk("WDATA", rf_wdata, e[38] ? e[31:0] : 32'h0);
        chk("LATENCY", cyc - a, 3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [3:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    mregs[addr] = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] opc, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input bit expect_it, input bit keep);
    int budget = 0;
    logic [31:0] a, b, r;
    logic c, wr, legal;
    instr = {opc, rd, rs1, rs2};
    instr_valid = 1'b1;
    while (!instr_ready && budget < 20) begin @(negedge clk); budget++; end
    if (!instr_ready) begin
      chk("ACCEPT_TIMEOUT", 0, 1);
      instr_valid = 1'b0;
      prev_keep = 1'b0;
      return;
    end
    if (prev_keep) chk("ACCEPT_GAP", cyc - last_acc, 4);
    last_acc = cyc;
    prev_keep = keep;
    if (expect_it) begin
      a = mregs[rs1]; b = mregs[rs2]; r = '0; c = 1'b0;
      wr = (opc <= 4'hA); legal = (opc <= 4'hB);
      case (opc)
        4'h0: {c, r} = {1'b0, a} + {1'b0, b};
        4'h1: begin r = a - b; c = (a < b); end
        4'h2: r = a & b;
        4'h3: r = a | b;
        4'h4: r = a ^ b;
        4'h5: r = a << b[4:0];
        4'h6: r = a >> b[4:0];
        4'h7: r = $signed(a) >>> b[4:0];
        4'h8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'h9: r = (a < b) ? 32'd1 : 32'd0;
        4'hA: r = a;
        default: r = '0;
      endcase
      if (wr) begin
        mres = r; mzero = (r == 32'h0); mcarry = c; mregs[rd] = r;
      end
      exp_q.push_back({~legal, wr, mzero, mcarry, wr ? rd : 4'h0, mres});
      acc_q.push_back(cyc);
      retire_exp++;
    end
    @(negedge clk);
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 60) begin @(negedge clk); budget++; end
    if (exp_q.size() != 0) begin
      chk("DRAIN_TIMEOUT", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    chk("RST_OUTS", {rf_en, rf_rd, rf_wr, done, illegal, zero, carry}, 7'h0);
    chk("RST_SELS", {rf_sel_o1, rf_sel_o2, rf_sel_i1}, 12'h0);
    chk("RST_DATA", {result, rf_wdata}, 64'h0);
    chk("RST_READY", instr_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) preload(i[3:0], $urandom);

    // Abort an ADD while it sits in READ.
    issue(4'h0, 4'h8, 4'h1, 4'h2, 1'b0, 1'b0);
    chk("MID_READ_STROBE", {rf_en, rf_rd}, 2'b11);
    rst = 1'b1;
    #1;
    chk("MID_RST_OUTS", {rf_en, rf_rd, rf_wr, done, illegal, zero, carry}, 7'h0);
    chk("MID_RST_DATA", {result, rf_wdata}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("MID_RST_IDLE", instr_ready, 1);
    repeat (6) @(negedge clk);
    chk("MID_RST_NO_WR", wr_cnt, 0);
    chk("MID_RST_DONE", done, 0);
    chk("MID_RST_R8", regs[8], mregs[8]);

    // Directed cases
    preload(4'h1, 32'hFFFF_FFFF);
    preload(4'h2, 32'h1);
    issue(4'h0, 4'h3, 4'h1, 4'h2, 1'b1, 1'b0);   // ADD wraps to 0, carry
    drain();
    preload(4'h1, 32'h5);
    issue(4'h1, 4'h4, 4'h2, 4'h1, 1'b1, 1'b0);   // SUB 1-5
    issue(4'h7, 4'h5, 4'h4, 4'h2, 1'b1, 1'b0);   // SRA
    issue(4'h8, 4'h6, 4'h4, 4'h2, 1'b1, 1'b0);   // SLT
    issue(4'h9, 4'h7, 4'h4, 4'h2, 1'b1, 1'b0);   // SLTU
    drain();
    chk("SUB_R4", regs[4], 32'hFFFF_FFFC);
    chk("SRA_R5", regs[5], 32'hFFFF_FFFE);
    chk("SLT_R6", regs[6], 32'h1);
    chk("SLTU_R7", regs[7], 32'h0);
    chk("ADD_R3", regs[3], 32'h0);
    issue(4'hE, 4'h9, 4'h1, 4'h2, 1'b1, 1'b0);   // illegal
    issue(4'hB, 4'h9, 4'h1, 4'h2, 1'b1, 1'b0);   // NOP
    issue(4'h0, 4'h2, 4'h2, 4'h2, 1'b1, 1'b0);   // rd == rs1 == rs2
    drain();

    // Back-to-back with instr_valid held
    issue(4'h4, 4'hA, 4'h3, 4'h4, 1'b1, 1'b1);
    issue(4'h5, 4'hB, 4'h5, 4'h2, 1'b1, 1'b1);
    issue(4'hA, 4'hC, 4'h6, 4'h0, 1'b1, 1'b0);
    drain();

    // Random burst, all opcodes
    for (int i = 0; i < 16; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'b1, (i != 15));
    end
    drain();

    for (int i = 0; i < 16; i++) chk($sformatf("REG%0d", i), regs[i], mregs[i]);
`ifdef EXEC_RETIRE_CNT_EN
    chk("RETIRE_CNT", retire_cnt, retire_exp);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
